// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write-back path.
// Requester IDs also encode the round-robin "last granted" state.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 1 << ADDR_W;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write bits.
// A set and a clear on the same edge leave the bit set. Register 0 never reads as busy.
module reg_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  output logic [(1<<ADDR_W)-1:0]   busy
);

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // The clear is applied before the set, so a reservation always survives a write to the same register.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (set_en && (set_addr != '0)) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Round-robin write-back arbiter between the ALU (A) and load (B) paths.
// It owns the register-file write port and the pending-write scoreboard.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [ADDR_W-1:0]       a_rd,
  input  logic [DATA_W-1:0]       a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [ADDR_W-1:0]       b_rd,
  input  logic [DATA_W-1:0]       b_data,
  input  logic                    rsv_valid,
  input  logic [ADDR_W-1:0]       rsv_rd,
  output logic                    rf_we,
  output logic [ADDR_W-1:0]       rf_rw,
  output logic [DATA_W-1:0]       rf_din,
  output logic [(1<<ADDR_W)-1:0]  busy
);

  logic              lastGrant_q, lastGrant_d;
  logic              rfWe_q, rfWe_d;
  logic [ADDR_W-1:0] rfRw_q, rfRw_d;
  logic [DATA_W-1:0] rfDin_q, rfDin_d;
  logic              grantA, grantB;

  // On a conflict, the requester that was not granted most recently wins.
  assign grantA = !reset && a_valid && (!b_valid || (lastGrant_q == REQ_B));
  assign grantB = !reset && b_valid && (!a_valid || (lastGrant_q == REQ_A));

  assign a_ready = grantA;
  assign b_ready = grantB;

  always_comb begin
    lastGrant_d = lastGrant_q;
    rfWe_d      = 1'b0;
    rfRw_d      = rfRw_q;
    rfDin_d     = rfDin_q;
    if (grantA) begin
      lastGrant_d = REQ_A;
      rfWe_d      = (a_rd != '0);
      rfRw_d      = a_rd;
      rfDin_d     = a_data;
    end else if (grantB) begin
      lastGrant_d = REQ_B;
      rfWe_d      = (b_rd != '0);
      rfRw_d      = b_rd;
      rfDin_d     = b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant_q <= REQ_B;
      rfWe_q      <= 1'b0;
      rfRw_q      <= '0;
      rfDin_q     <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      rfWe_q      <= rfWe_d;
      rfRw_q      <= rfRw_d;
      rfDin_q     <= rfDin_d;
    end
  end

  assign rf_we  = rfWe_q;
  assign rf_rw  = rfRw_q;
  assign rf_din = rfDin_q;

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (rsv_valid),
    .set_addr (rsv_rd),
    .clr_en   (rfWe_q),
    .clr_addr (rfRw_q),
    .busy     (busy)
  );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Testbench for regfile_wb_ctrl. Directed vectors drive the block. A behavioural
// model with a register-file image is compared against the DUT every cycle.
module tb_regfile_wb_ctrl;
  import regfile_pkg::*;

  logic              clk;
  logic              reset;
  logic              a_valid, a_ready, b_valid, b_ready;
  logic [ADDR_W-1:0] a_rd, b_rd, rsv_rd, rf_rw;
  logic [DATA_W-1:0] a_data, b_data, rf_din;
  logic              rsv_valid, rf_we;
  logic [NREGS-1:0]  busy;

  int total = 0;
  int bad   = 0;

  regfile_wb_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .rsv_valid (rsv_valid),
    .rsv_rd    (rsv_rd),
    .rf_we     (rf_we),
    .rf_rw     (rf_rw),
    .rf_din    (rf_din),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the write port, the scoreboard as a bit array, a register-file image and a grant log.
  bit              modelOn = 0;
  bit              favourA = 1;
  bit              mWe     = 0;
  int              mRw     = 0;
  logic [31:0]     mDin    = '0;
  bit              mBusy [NREGS];
  logic [31:0]     mRf   [NREGS];
  int              grantLog [$];
  bit              goA, goB;

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      mBusy[i] = 0;
      mRf[i]   = '0;
    end
  end

  always @(posedge clk) begin
    if (mWe && mRw != 0) mRf[mRw] = mDin;
    if (reset) begin
      modelOn = 1;
      favourA = 1;
      mWe     = 0;
      mRw     = 0;
      mDin    = '0;
      for (int i = 0; i < NREGS; i++) mBusy[i] = 0;
    end else begin
      goA = a_valid && (!b_valid || favourA);
      goB = b_valid && !goA;
      if (mWe) mBusy[mRw] = 0;
      if (rsv_valid && rsv_rd != 0) mBusy[int'(rsv_rd)] = 1;
      if (goA) begin
        mWe = (a_rd != 0); mRw = int'(a_rd); mDin = a_data; favourA = 0;
        grantLog.push_back(0);
      end else if (goB) begin
        mWe = (b_rd != 0); mRw = int'(b_rd); mDin = b_data; favourA = 1;
        grantLog.push_back(1);
      end else begin
        mWe = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  logic [NREGS-1:0] busyPacked;
  always @(negedge clk) begin
    if (modelOn) begin
      for (int i = 0; i < NREGS; i++) busyPacked[i] = mBusy[i];
      checkOutput("a_ready", 32'(a_ready),
                  32'(!reset && a_valid && (!b_valid || favourA)));
      checkOutput("b_ready", 32'(b_ready),
                  32'(!reset && b_valid && (!a_valid || !favourA)));
      checkOutput("oneGrant", 32'(a_ready && b_ready), 32'd0);
      checkOutput("rf_we", 32'(rf_we), 32'(mWe));
      checkOutput("rf_rw", 32'(rf_rw), 32'(mRw));
      checkOutput("rf_din", rf_din, mDin);
      checkOutput("busy", busy, busyPacked);
    end
  end

  task automatic applyStimulus(input bit rst,
                               input bit av, input int ard, input logic [31:0] ad,
                               input bit bv, input int brd, input logic [31:0] bd,
                               input bit rv, input int rrd);
    reset     = rst;
    a_valid   = av; a_rd = ADDR_W'(ard); a_data = ad;
    b_valid   = bv; b_rd = ADDR_W'(brd); b_data = bd;
    rsv_valid = rv; rsv_rd = ADDR_W'(rrd);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1, 1, 4, 32'h44, 0, 0, 0, 0, 0);
    nextCycle();
    #1;
    checkOutput("resetReadyA", 32'(a_ready), 32'd0);
    checkOutput("resetWe", 32'(rf_we), 32'd0);
    checkOutput("resetBusy", busy, 32'd0);
    checkOutput("resetRw", 32'(rf_rw), 32'd0);
    nextCycle();

    // Single write to x5 with a prior reservation.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5);
    nextCycle();
    applyStimulus(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    #1;
    checkOutput("single.aReady", 32'(a_ready), 32'd1);
    checkOutput("single.busyAfterRsv", 32'(busy[5]), 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("single.we", 32'(rf_we), 32'd1);
    checkOutput("single.rw", 32'(rf_rw), 32'd5);
    checkOutput("single.din", rf_din, 32'hDEADBEEF);
    nextCycle();
    checkOutput("single.busyClear", 32'(busy[5]), 32'd0);
    checkOutput("single.rfImage", mRf[5], 32'hDEADBEEF);

    // Continuous conflict after reset: A, B, A, B.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    grantLog.delete();
    applyStimulus(0, 1, 1, 32'd1, 1, 2, 32'd2, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("conflict.aReady", 32'(a_ready), 32'((i % 2) == 0));
      checkOutput("conflict.bReady", 32'(b_ready), 32'((i % 2) == 1));
      nextCycle();
      checkOutput("conflict.rw", 32'(rf_rw), ((i % 2) == 0) ? 32'd1 : 32'd2);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("conflict.logSize", 32'(grantLog.size()), 32'd4);
    for (int i = 0; i < 4 && i < grantLog.size(); i++)
      checkOutput("conflict.logOrder", 32'(grantLog[i]), 32'(i % 2));
    nextCycle();

    // x0 write-back and reservation are both dropped.
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h1234, 1, 0);
    #1;
    checkOutput("x0.bReady", 32'(b_ready), 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("x0.we", 32'(rf_we), 32'd0);
    checkOutput("x0.busy", busy, 32'd0);
    checkOutput("x0.rfImage", mRf[0], 32'd0);
    nextCycle();

    // Reservation of x7 lands on the same edge as the x7 write: set wins.
    applyStimulus(0, 1, 7, 32'h77, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7);
    #1;
    checkOutput("collide.we", 32'(rf_we), 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("collide.busy7", 32'(busy[7]), 32'd1);
    applyStimulus(0, 1, 7, 32'h78, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("collide.busy7Clear", 32'(busy[7]), 32'd0);

    // Back-to-back writes from A to x1..x8.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 1, i, 32'(i * 16), 0, 0, 0, 0, 0);
      #1;
      checkOutput("b2b.aReady", 32'(a_ready), 32'd1);
      nextCycle();
      checkOutput("b2b.we", 32'(rf_we), 32'd1);
      checkOutput("b2b.rw", 32'(rf_rw), 32'(i));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("b2b.rfImage8", mRf[8], 32'd128);

    // Reset lands while the x3 write is captured.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3);
    nextCycle();
    applyStimulus(0, 1, 3, 32'd9, 1, 4, 32'd4, 0, 0);
    #1;
    checkOutput("midRst.busy3", 32'(busy[3]), 32'd1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("midRst.we", 32'(rf_we), 32'd0);
    checkOutput("midRst.busy", busy, 32'd0);
    applyStimulus(0, 1, 3, 32'd9, 1, 4, 32'd4, 0, 0);
    #1;
    checkOutput("midRst.aFirst", 32'(a_ready), 32'd1);
    checkOutput("midRst.bWaits", 32'(b_ready), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
